// File: rtl/dac_sched_pkg.sv
// Shared types and defaults for the DAC sample scheduler: FSM state, default
// timing constants, stereo sample container and a counter-width helper.
package dac_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_CLK_DIV = 1000;  // 48 MHz / 48 kHz
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_DATA_W  = 16;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } stereo_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: asserts tick on the last cycle of every CLK_DIV-cycle
// period while enabled; disabling forces the count back to zero.
module sample_tick_gen
  import dac_sched_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic arst,
  input  logic enable,
  output logic tick
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      div_cnt_reg <= '0;
    end else if (!enable || div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick = enable && (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/dac_sample_scheduler.sv
// Requests one sample per period from the generator, waits with a timeout for
// its handshake and loads the DAC; a miss repeats the held sample and flags an
// underrun. Define DAC_SCHED_UNDERRUN_CNT_EN to add a saturating miss counter.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  output logic              sample_ce,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_left,
  input  logic [DATA_W-1:0] src_right,
  output logic              src_ack,
  output logic [DATA_W-1:0] dac_left,
  output logic [DATA_W-1:0] dac_right,
  output logic              dac_load,
  output logic              busy,
  output logic              underrun
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  // A tick must never land while a transaction is still waiting.
  generate
    if (CLK_DIV < 8 || CLK_DIV > 65535 || TIMEOUT < 1 || TIMEOUT + 2 >= CLK_DIV) begin : g_bad_params
      $fatal(1, "dac_sample_scheduler: need 8<=CLK_DIV<=65535 and 1<=TIMEOUT<CLK_DIV-2");
    end
  endgenerate

  localparam int TMO_W = cnt_width(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } sample_t;

  logic       tick;
  state_t     state_reg, state_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  sample_t    dac_next;
  logic       sample_ce_next, ack_next, load_next, underrun_next;

  sample_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .arst  (arst),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    state_next     = state_reg;
    tmo_next       = tmo_reg;
    dac_next       = '{left: dac_left, right: dac_right};
    sample_ce_next = 1'b0;
    ack_next       = 1'b0;
    load_next      = 1'b0;
    underrun_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick) begin
          state_next     = WAIT;
          tmo_next       = '0;
          sample_ce_next = 1'b1;
        end
      end
      WAIT: begin
        // Valid takes priority over an expiring timeout on the same edge.
        if (src_valid) begin
          dac_next   = '{left: src_left, right: src_right};
          ack_next   = 1'b1;
          load_next  = 1'b1;
          state_next = IDLE;
        end else if (tmo_reg == TMO_LAST) begin
          load_next     = 1'b1;
          underrun_next = 1'b1;
          state_next    = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= IDLE;
      tmo_reg   <= '0;
      sample_ce <= 1'b0;
      src_ack   <= 1'b0;
      dac_load  <= 1'b0;
      underrun  <= 1'b0;
      busy      <= 1'b0;
      dac_left  <= '0;
      dac_right <= '0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      sample_ce <= sample_ce_next;
      src_ack   <= ack_next;
      dac_load  <= load_next;
      underrun  <= underrun_next;
      busy      <= (state_next == WAIT);
      dac_left  <= dac_next.left;
      dac_right <= dac_next.right;
    end
  end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      underrun_cnt <= '0;
    end else if (underrun_next && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed plus randomized bench for dac_sample_scheduler (CLK_DIV=16,
// TIMEOUT=4) checked every cycle against a transaction-level reference model.
module tb_dac_sample_scheduler;
  import dac_sched_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int TIMEOUT = 4;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              enable = 1'b0;
  logic              src_valid = 1'b0;
  logic [DATA_W-1:0] src_left = '0;
  logic [DATA_W-1:0] src_right = '0;
  logic              sample_ce, src_ack, dac_load, busy, underrun;
  logic [DATA_W-1:0] dac_left, dac_right;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  dac_sample_scheduler #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .enable   (enable),
    .sample_ce(sample_ce),
    .src_valid(src_valid),
    .src_left (src_left),
    .src_right(src_right),
    .src_ack  (src_ack),
    .dac_left (dac_left),
    .dac_right(dac_right),
    .dac_load (dac_load),
    .busy     (busy),
    .underrun (underrun)
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: enabled-edge run length, pending request age, held sample.
  int      m_run;
  bit      m_pending;
  int      m_age;
  stereo_t m_dac;
  bit      m_ce, m_ack, m_load, m_und;
  int      m_ucnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pending = 0; m_age = 0; m_dac = '0;
    m_ce = 0; m_ack = 0; m_load = 0; m_und = 0; m_ucnt = 0;
  endtask

  task automatic model_edge();
    bit period_end;
    m_ce = 0; m_ack = 0; m_load = 0; m_und = 0;
    if (arst) begin
      model_reset();
      return;
    end
    period_end = enable && ((m_run % CLK_DIV) == CLK_DIV - 1);
    m_run = enable ? m_run + 1 : 0;
    if (m_pending) begin
      m_age++;
      if (src_valid) begin
        m_dac = '{left: src_left, right: src_right};
        m_ack = 1; m_load = 1; m_pending = 0;
      end else if (m_age == TIMEOUT) begin
        m_load = 1; m_und = 1; m_pending = 0;
        if (m_ucnt < 16'hFFFF) m_ucnt++;
      end
    end else if (period_end) begin
      m_ce = 1; m_pending = 1; m_age = 0;
    end
  endtask

  task automatic compare_all();
    chk("sample_ce", sample_ce, m_ce);
    chk("src_ack",   src_ack,   m_ack);
    chk("dac_load",  dac_load,  m_load);
    chk("underrun",  underrun,  m_und);
    chk("busy",      busy,      m_pending);
    chk("dac_left",  dac_left,  m_dac.left);
    chk("dac_right", dac_right, m_dac.right);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, m_ucnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset(input int hold_edges);
    arst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (hold_edges) step();
    arst = 1'b0;
  endtask

  task automatic wait_ce(input string tag, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (sample_ce !== 1'b1 && edges < 200);
    chk({tag, "_ce_seen"}, sample_ce, 1'b1);
  endtask

  initial begin
    int edges, last_ce, ce_count;
    model_reset();

    // Reset and run
    #2;
    async_reset(3);
    enable = 1'b1;
    wait_ce("first", edges);
    chk("first_ce_latency", edges, CLK_DIV);

    // Normal handshake, valid two cycles after sample_ce
    last_ce = cyc;
    step(); step();
    src_valid = 1'b1; src_left = 16'h1234; src_right = 16'hABCD;
    step();
    src_valid = 1'b0;
    chk("hs_ack", src_ack, 1'b1);
    chk("hs_load", dac_load, 1'b1);
    chk("hs_left", dac_left, 16'h1234);
    chk("hs_right", dac_right, 16'hABCD);

    // Sample period over 10 samples with an immediate responder
    for (int i = 0; i < 10; i++) begin
      wait_ce("period", edges);
      chk("ce_period", cyc - last_ce, CLK_DIV);
      last_ce = cyc;
      src_valid = 1'b1;
      src_left = (i == 9) ? 16'h1234 : 16'($urandom);
      src_right = (i == 9) ? 16'hABCD : 16'($urandom);
      step();
      src_valid = 1'b0;
    end

    // Underrun twice: held sample repeats
    for (int k = 1; k <= 2; k++) begin
      wait_ce("miss", edges);
      repeat (TIMEOUT - 1) step();
      chk("pre_timeout_underrun", underrun, 1'b0);
      step();
      chk("miss_underrun", underrun, 1'b1);
      chk("miss_load", dac_load, 1'b1);
      chk("miss_left", dac_left, 16'h1234);
      chk("miss_right", dac_right, 16'hABCD);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
      chk("miss_cnt", underrun_cnt, k);
`endif
    end

    // Valid arrives on the timeout edge
    wait_ce("race", edges);
    repeat (TIMEOUT - 1) step();
    src_valid = 1'b1; src_left = 16'h5555; src_right = 16'hAAAA;
    step();
    src_valid = 1'b0;
    chk("race_ack", src_ack, 1'b1);
    chk("race_underrun", underrun, 1'b0);
    chk("race_left", dac_left, 16'h5555);

    // Stray valid in IDLE
    src_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stray_ack", src_ack, 1'b0);
    end
    src_valid = 1'b0;

    // Disable mid-WAIT: sample completes, then silence
    wait_ce("dis", edges);
    enable = 1'b0;
    step();
    src_valid = 1'b1; src_left = 16'h0F0F; src_right = 16'hF0F0;
    step();
    src_valid = 1'b0;
    chk("dis_ack", src_ack, 1'b1);
    ce_count = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sample_ce === 1'b1) ce_count++;
    end
    chk("dis_no_ce", ce_count, 0);

    // Reset mid-WAIT
    enable = 1'b1;
    wait_ce("rst", edges);
    step();
    chk("rst_pre_busy", busy, 1'b1);
    async_reset(1);
    wait_ce("rst_after", edges);
    chk("rst_ce_latency", edges, CLK_DIV);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      src_valid = ($urandom_range(0, 3) == 0);
      src_left  = 16'($urandom);
      src_right = 16'($urandom);
      if ($urandom_range(0, 799) == 0) async_reset($urandom_range(1, 3));
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Sequences the audio sample path between the NCO sample generator and the PCM5102 I2S serializer.
- Derives the sample-rate strobe from the 48 MHz system clock and issues a one-cycle sample_ce to the generator.
- Waits, with a timeout, for the generator's sample handshake and presents a held stereo sample plus a load strobe to the DAC.
- On a missed sample it repeats the previous sample and flags an underrun.

Parameters:
- CLK_DIV, 1000, system clocks per sample period (48 MHz / 48 kHz); legal range 8..65535.
- DATA_W, 16, sample width per channel.
- TIMEOUT, 64, max WAIT cycles before underrun; requires TIMEOUT + 2 < CLK_DIV, checked at elaboration (fatal).

Ports:
- clk  in  1  system clock, 48 MHz
- arst  in  1  reset, asynchronous, active-high
- enable  in  1  run; low holds the divider at 0
- sample_ce  out  1  one-cycle request to the sample generator
- src_valid  in  1  generator sample valid
- src_left  in  DATA_W  left sample, two's complement
- src_right  in  DATA_W  right sample
- src_ack  out  1  one-cycle acknowledge of a captured sample
- dac_left  out  DATA_W  held left sample to the DAC
- dac_right  out  DATA_W  held right sample to the DAC
- dac_load  out  1  one-cycle strobe; dac_left/right are new or repeated
- busy  out  1  high while in WAIT
- underrun  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (arst high, any time): state=IDLE; div_cnt=0; tmo_cnt=0. All outputs 0, including dac_left and dac_right. Reset mid-WAIT aborts with no ack and no load.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps while enable=1. When enable=0, div_cnt is forced to 0. tick = enable && div_cnt==CLK_DIV-1.
- States: IDLE, WAIT (2-state FSM). All outputs are registered.
- IDLE:
  - On an edge with tick: sample_ce<=1 for exactly one cycle; state<=WAIT; tmo_cnt<=0.
  - src_valid is ignored in IDLE; no ack is issued.
- WAIT (busy=1):
  - src_valid is sampled from the first edge after sample_ce rises. A source that holds valid combinationally is captured one cycle after sample_ce.
  - Edge with src_valid=1: dac_left/dac_right<=src_left/src_right; src_ack<=1 and dac_load<=1 for one cycle; state<=IDLE.
  - Edge with src_valid=0 and tmo_cnt==TIMEOUT-1: dac regs unchanged; dac_load<=1 and underrun<=1 for one cycle; state<=IDLE.
  - Otherwise tmo_cnt increments.
  - src_valid on the timeout edge: valid wins, no underrun.
- Latency: sample_ce rises 1 cycle after the tick edge. dac_load follows src_valid by 1 edge. Worst case is TIMEOUT cycles after sample_ce.
- A tick cannot occur outside IDLE (guaranteed by the parameter check). The divider never stalls, so the sample period stays exactly CLK_DIV cycles.
- enable falling during WAIT: the transaction completes normally; no further ticks.
- Widths: tmo_cnt is clog2(TIMEOUT) bits; div_cnt is clog2(CLK_DIV) bits. Samples pass through unmodified.

Optional Feature:
- Macro: DAC_SCHED_UNDERRUN_CNT_EN.
- When defined: adds output underrun_cnt (16 bits). It increments on each underrun pulse, saturates at 0xFFFF and resets to 0 on arst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package dac_sched_pkg holds: the state enum (IDLE, WAIT), the default CLK_DIV and TIMEOUT constants, and a stereo sample struct {left, right} of DATA_W bits.
- Sub-module sample_tick_gen (parameter CLK_DIV; ports clk, arst, enable, tick) contains the divider. The FSM, timeout counter and output regs stay in the top.

Test Plan (CLK_DIV=16, TIMEOUT=4 unless noted):
- Reset and run: hold arst for 3 cycles, then enable=1. First sample_ce appears 16 cycles after enable. All outputs are 0 until then.
- Normal handshake: src_valid asserted 2 cycles after sample_ce with L=0x1234, R=0xABCD. On the next edge src_ack=1 and dac_load=1 for 1 cycle, dac_left=0x1234, dac_right=0xABCD. Sample_ce period is exactly 16 cycles over 10 samples.
- Underrun: src_valid never asserted after a prior sample of 0x1234/0xABCD. underrun and dac_load pulse 4 cycles after sample_ce; dac regs still hold 0x1234/0xABCD. With DAC_SCHED_UNDERRUN_CNT_EN defined, underrun_cnt=1, then 2 on the next miss.
- Timeout race: src_valid rises exactly on the 4th WAIT edge. Data is captured, src_ack=1, underrun stays 0.
- Stray valid and disable: src_valid=1 in IDLE produces no src_ack. Dropping enable mid-WAIT lets that sample complete, after which no sample_ce is issued for 100 cycles.
- Reset mid-WAIT: arst pulsed 1 cycle after sample_ce. All outputs go 0 immediately (async). With enable kept high, the next sample_ce comes 16 cycles after arst release.
